// File: rtl/dragon_body_if.sv
// Signal bundle between the dragon head stage / sprite renderer and the dragon body.
// The head stage and renderer drive the master side; dragon_body is the slave.
interface dragon_body_if;
    logic       move_en;
    logic [7:0] head_location;
    logic [1:0] head_direction;
    logic       grow;
    logic       shrink;
    logic [7:0] player_location;
    logic [3:0] seg_rd_idx;
    logic [3:0] body_length;
    logic [7:0] seg_rd_location;
    logic [1:0] seg_rd_direction;
    logic       seg_rd_valid;
    logic       player_hit;
    logic       self_hit;
    logic       dragon_dead;

    modport master (
        output move_en, head_location, head_direction, grow, shrink, player_location, seg_rd_idx,
        input  body_length, seg_rd_location, seg_rd_direction, seg_rd_valid,
        input  player_hit, self_hit, dragon_dead
    );

    modport slave (
        input  move_en, head_location, head_direction, grow, shrink, player_location, seg_rd_idx,
        output body_length, seg_rd_location, seg_rd_direction, seg_rd_valid,
        output player_hit, self_hit, dragon_dead
    );
endinterface

// File: rtl/dragon_body.sv
// Dragon body: shift buffer of trailing segments behind the head, growth/shrink bookkeeping,
// registered collision flags and a registered random-access segment read port.
module dragon_body #(
    parameter int         MAX_SEGMENTS = 15,
    parameter int         RESET_LENGTH = 3,
    parameter logic [7:0] RESET_HEAD   = 8'h77
) (
    input  logic         frame_clk,
    input  logic         rst,
    dragon_body_if.slave bus
);
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [3:0] MAX_LEN   = 4'(MAX_SEGMENTS);
    localparam logic [3:0] RST_LEN   = 4'(RESET_LENGTH);

    logic [7:0] head_q;
    logic [1:0] head_dir_q;
    logic [7:0] seg_loc [MAX_SEGMENTS];
    logic [1:0] seg_dir [MAX_SEGMENTS];
    logic [3:0] length;
    logic [1:0] pending;
    logic       dead_q;
    logic       player_hit_q;
    logic       self_hit_q;
    logic [7:0] rd_loc_q;
    logic [1:0] rd_dir_q;
    logic       rd_valid_q;

    logic       step;
    logic       grow_ok;
    logic       shrink_ok;
    logic       seg_add;
    logic [1:0] pending_inc;
    logic [1:0] pending_nxt;
    logic [3:0] length_nxt;
    logic       dies;
    logic       player_hit_nxt;
    logic       self_hit_nxt;

    // A grow arriving with a step is counted before the step looks at pending.
    always_comb begin
        step        = bus.move_en & ~dead_q;
        grow_ok     = bus.grow & ~bus.shrink & ~dead_q;
        shrink_ok   = bus.shrink & ~bus.grow & ~dead_q & (length != 4'd0);
        pending_inc = (grow_ok && pending != 2'd3) ? pending + 2'd1 : pending;
        seg_add     = 1'b0;
        pending_nxt = pending_inc;
        if (step && pending_inc != 2'd0) begin
            if (length < MAX_LEN) begin
                seg_add     = 1'b1;
                pending_nxt = pending_inc - 2'd1;
            end else begin
                pending_nxt = 2'd0;
            end
        end
        length_nxt = length;
        if (seg_add && !shrink_ok) begin
            length_nxt = length + 4'd1;
        end else if (!seg_add && shrink_ok) begin
            length_nxt = length - 4'd1;
        end
        dies = shrink_ok & ~seg_add & (length == 4'd1);
    end

    always_comb begin
        player_hit_nxt = (bus.player_location == head_q);
        self_hit_nxt   = 1'b0;
        for (int i = 0; i < MAX_SEGMENTS; i++) begin
            if (4'(i) < length) begin
                if (seg_loc[i] == bus.player_location) player_hit_nxt = 1'b1;
                if (seg_loc[i] == head_q) self_hit_nxt = 1'b1;
            end
        end
        if (dead_q) begin
            player_hit_nxt = 1'b0;
            self_hit_nxt   = 1'b0;
        end
    end

    always_ff @(posedge frame_clk or negedge rst) begin
        if (!rst) begin
            head_q     <= RESET_HEAD;
            head_dir_q <= DIR_RIGHT;
            // Initial body trails to the left of the head, wrapping within the row.
            for (int i = 0; i < MAX_SEGMENTS; i++) begin
                seg_loc[i] <= {RESET_HEAD[7:4], RESET_HEAD[3:0] - 4'(i + 1)};
                seg_dir[i] <= DIR_RIGHT;
            end
            length       <= RST_LEN;
            pending      <= 2'd0;
            dead_q       <= 1'b0;
            player_hit_q <= 1'b0;
            self_hit_q   <= 1'b0;
            rd_loc_q     <= 8'h00;
            rd_dir_q     <= 2'd0;
            rd_valid_q   <= 1'b0;
        end else begin
            if (step) begin
                head_q     <= bus.head_location;
                head_dir_q <= bus.head_direction;
                seg_loc[0] <= head_q;
                seg_dir[0] <= head_dir_q;
                for (int i = 1; i < MAX_SEGMENTS; i++) begin
                    seg_loc[i] <= seg_loc[i-1];
                    seg_dir[i] <= seg_dir[i-1];
                end
            end
            length       <= length_nxt;
            pending      <= pending_nxt;
            if (dies) dead_q <= 1'b1;
            player_hit_q <= player_hit_nxt;
            self_hit_q   <= self_hit_nxt;
            if (bus.seg_rd_idx < MAX_LEN) begin
                rd_loc_q   <= seg_loc[bus.seg_rd_idx];
                rd_dir_q   <= seg_dir[bus.seg_rd_idx];
                rd_valid_q <= (bus.seg_rd_idx < length);
            end else begin
                rd_loc_q   <= 8'h00;
                rd_dir_q   <= 2'd0;
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign bus.body_length      = length;
    assign bus.seg_rd_location  = rd_loc_q;
    assign bus.seg_rd_direction = rd_dir_q;
    assign bus.seg_rd_valid     = rd_valid_q;
    assign bus.player_hit       = player_hit_q;
    assign bus.self_hit         = self_hit_q;
    assign bus.dragon_dead      = dead_q;
endmodule

// File: tb/tb_dragon_body.sv
// Bench for dragon_body: directed vector table, hand-written corner sequences and
// randomized play checked against a queue-based model of the body.
module tb_dragon_body;
    logic frame_clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    dragon_body_if bus();

    dragon_body #(.MAX_SEGMENTS(15), .RESET_LENGTH(3), .RESET_HEAD(8'h77)) dut (
        .frame_clk(frame_clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic       me;
        logic [7:0] hl;
        logic [1:0] hd;
        logic       g;
        logic       s;
        logic [7:0] pl;
        logic [3:0] idx;
        logic [3:0] e_len;
        logic [7:0] e_loc;
        logic [1:0] e_dir;
        logic       e_val;
        logic       e_phit;
        logic       e_shit;
    } vec_t;

    vec_t vecs[23];

    // Model: head plus a queue of every buffered tile, nearest the head first.
    logic [7:0] m_head;
    logic [1:0] m_hdir;
    logic [7:0] m_loc[$];
    logic [1:0] m_dir[$];
    int         m_len;
    int         m_pend;
    bit         m_dead;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic me, input logic [7:0] hl, input logic [1:0] hd, input logic g,
                         input logic s, input logic [7:0] pl, input logic [3:0] idx);
        bus.move_en         = me;
        bus.head_location   = hl;
        bus.head_direction  = hd;
        bus.grow            = g;
        bus.shrink          = s;
        bus.player_location = pl;
        bus.seg_rd_idx      = idx;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] pl, input logic [3:0] idx);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, pl, idx);
    endtask

    function automatic void model_reset();
        m_head = 8'h77;
        m_hdir = 2'd1;
        m_loc.delete();
        m_dir.delete();
        for (int i = 0; i < 15; i++) begin
            m_loc.push_back({4'h7, 4'(7 - (i + 1))});
            m_dir.push_back(2'd1);
        end
        m_len  = 3;
        m_pend = 0;
        m_dead = 0;
    endfunction

    task automatic apply_reset();
        bus.move_en = 0; bus.head_location = 0; bus.head_direction = 0; bus.grow = 0;
        bus.shrink = 0; bus.player_location = 0; bus.seg_rd_idx = 0;
        rst = 1'b0;
        @(negedge frame_clk);
        @(negedge frame_clk);
        rst = 1'b1;
        model_reset();
    endtask

    function automatic logic [7:0] neighbour(input logic [7:0] t, input int d);
        logic [3:0] x, y;
        x = t[3:0];
        y = t[7:4];
        case (d)
            0: y = y - 4'd1;
            1: x = x + 4'd1;
            2: y = y + 4'd1;
            default: x = x - 4'd1;
        endcase
        return {y, x};
    endfunction

    task automatic rand_cycle(input int n);
        logic       me, g, s;
        logic [7:0] hl, pl;
        logic [1:0] hd;
        logic [3:0] idx;
        logic [7:0] e_loc;
        logic [1:0] e_dir;
        logic       e_val, e_phit, e_shit;
        int         d, gi, si;
        me  = ($urandom_range(0, 1) == 1);
        g   = ($urandom_range(0, 5) == 0);
        s   = ($urandom_range(0, 24) == 0);
        d   = $urandom_range(0, 3);
        hd  = 2'(d);
        hl  = neighbour(m_head, d);
        if ($urandom_range(0, 7) == 0) hl = m_loc[$urandom_range(0, 14)];
        case ($urandom_range(0, 2))
            0: pl = m_head;
            1: pl = m_loc[$urandom_range(0, 14)];
            default: pl = 8'($urandom);
        endcase
        idx = 4'($urandom_range(0, 15));

        e_phit = 0;
        e_shit = 0;
        if (!m_dead) begin
            e_phit = (pl == m_head);
            for (int i = 0; i < m_len; i++) begin
                if (m_loc[i] == pl) e_phit = 1;
                if (m_loc[i] == m_head) e_shit = 1;
            end
        end
        e_loc = (idx < 15) ? m_loc[idx] : 8'h00;
        e_dir = (idx < 15) ? m_dir[idx] : 2'd0;
        e_val = (int'(idx) < m_len) && (idx < 15);

        if (!m_dead) begin
            gi = (g && !s) ? 1 : 0;
            si = (s && !g && m_len > 0) ? 1 : 0;
            if (gi == 1 && m_pend < 3) m_pend++;
            if (me) begin
                m_loc.push_front(m_head);
                m_dir.push_front(m_hdir);
                void'(m_loc.pop_back());
                void'(m_dir.pop_back());
                m_head = hl;
                m_hdir = hd;
                if (m_pend > 0) begin
                    if (m_len < 15) begin
                        m_len++;
                        m_pend--;
                    end else begin
                        m_pend = 0;
                    end
                end
            end
            if (si == 1) begin
                m_len--;
                if (m_len == 0) m_dead = 1;
            end
        end

        drive(me, hl, hd, g, s, pl, idx);
        check($sformatf("r%0d len", n), 8'(bus.body_length), 8'(m_len));
        check($sformatf("r%0d dead", n), 8'(bus.dragon_dead), 8'(m_dead));
        check($sformatf("r%0d rd_loc", n), bus.seg_rd_location, e_loc);
        check($sformatf("r%0d rd_dir", n), 8'(bus.seg_rd_direction), 8'(e_dir));
        check($sformatf("r%0d rd_valid", n), 8'(bus.seg_rd_valid), 8'(e_val));
        check($sformatf("r%0d player_hit", n), 8'(bus.player_hit), 8'(e_phit));
        check($sformatf("r%0d self_hit", n), 8'(bus.self_hit), 8'(e_shit));
    endtask

    initial begin
        //           me  hl     hd  g  s  pl     idx | len  loc    dir val ph sh
        vecs[0]  = '{0, 8'h00, 0, 0, 0, 8'h00, 0,   3, 8'h76, 1, 1, 0, 0};
        vecs[1]  = '{0, 8'h00, 0, 0, 0, 8'h00, 1,   3, 8'h75, 1, 1, 0, 0};
        vecs[2]  = '{0, 8'h00, 0, 0, 0, 8'h00, 2,   3, 8'h74, 1, 1, 0, 0};
        vecs[3]  = '{0, 8'h00, 0, 0, 0, 8'h00, 3,   3, 8'h73, 1, 0, 0, 0};
        vecs[4]  = '{1, 8'h78, 1, 0, 0, 8'h00, 0,   3, 8'h76, 1, 1, 0, 0};
        vecs[5]  = '{1, 8'h79, 1, 0, 0, 8'h00, 0,   3, 8'h77, 1, 1, 0, 0};
        vecs[6]  = '{1, 8'h89, 2, 0, 0, 8'h00, 0,   3, 8'h78, 1, 1, 0, 0};
        vecs[7]  = '{0, 8'h00, 0, 0, 0, 8'h00, 0,   3, 8'h79, 1, 1, 0, 0};
        vecs[8]  = '{0, 8'h00, 0, 0, 0, 8'h00, 1,   3, 8'h78, 1, 1, 0, 0};
        vecs[9]  = '{0, 8'h00, 0, 0, 0, 8'h00, 2,   3, 8'h77, 1, 1, 0, 0};
        vecs[10] = '{0, 8'h00, 0, 1, 0, 8'h00, 3,   3, 8'h76, 1, 0, 0, 0};
        vecs[11] = '{1, 8'h99, 2, 0, 0, 8'h00, 0,   4, 8'h79, 1, 1, 0, 0};
        vecs[12] = '{0, 8'h00, 0, 0, 0, 8'h00, 3,   4, 8'h77, 1, 1, 0, 0};
        vecs[13] = '{0, 8'h00, 0, 1, 0, 8'h00, 0,   4, 8'h89, 2, 1, 0, 0};
        vecs[14] = '{0, 8'h00, 0, 1, 0, 8'h00, 0,   4, 8'h89, 2, 1, 0, 0};
        vecs[15] = '{0, 8'h00, 0, 1, 0, 8'h00, 0,   4, 8'h89, 2, 1, 0, 0};
        vecs[16] = '{0, 8'h00, 0, 1, 0, 8'h00, 0,   4, 8'h89, 2, 1, 0, 0};
        vecs[17] = '{1, 8'hA9, 2, 0, 0, 8'h00, 0,   5, 8'h89, 2, 1, 0, 0};
        vecs[18] = '{1, 8'hB9, 2, 0, 0, 8'h00, 0,   6, 8'h99, 2, 1, 0, 0};
        vecs[19] = '{1, 8'hC9, 2, 0, 0, 8'h00, 0,   7, 8'hA9, 2, 1, 0, 0};
        vecs[20] = '{0, 8'h00, 0, 0, 0, 8'hA9, 1,   7, 8'hA9, 2, 1, 1, 0};
        vecs[21] = '{0, 8'h00, 0, 0, 0, 8'h76, 7,   7, 8'h76, 1, 0, 0, 0};
        vecs[22] = '{0, 8'h00, 0, 0, 0, 8'hC9, 6,   7, 8'h77, 1, 1, 1, 0};

        apply_reset();
        check("reset len", 8'(bus.body_length), 8'd3);
        check("reset dead", 8'(bus.dragon_dead), 8'd0);
        check("reset player_hit", 8'(bus.player_hit), 8'd0);
        check("reset self_hit", 8'(bus.self_hit), 8'd0);
        check("reset rd_valid", 8'(bus.seg_rd_valid), 8'd0);
        check("reset rd_loc", bus.seg_rd_location, 8'h00);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].me, vecs[i].hl, vecs[i].hd, vecs[i].g, vecs[i].s, vecs[i].pl, vecs[i].idx);
            check($sformatf("v%0d len", i), 8'(bus.body_length), 8'(vecs[i].e_len));
            check($sformatf("v%0d rd_loc", i), bus.seg_rd_location, vecs[i].e_loc);
            check($sformatf("v%0d rd_dir", i), 8'(bus.seg_rd_direction), 8'(vecs[i].e_dir));
            check($sformatf("v%0d rd_valid", i), 8'(bus.seg_rd_valid), 8'(vecs[i].e_val));
            check($sformatf("v%0d player_hit", i), 8'(bus.player_hit), 8'(vecs[i].e_phit));
            check($sformatf("v%0d self_hit", i), 8'(bus.self_hit), 8'(vecs[i].e_shit));
        end

        // Grow+shrink cancel, then shrink to death; dead body ignores everything.
        apply_reset();
        drive(0, 8'h00, 0, 1, 1, 8'h00, 0);
        check("gs len", 8'(bus.body_length), 8'd3);
        drive(1, 8'h78, 1, 0, 0, 8'h00, 0);
        check("gs step len", 8'(bus.body_length), 8'd3);
        for (int k = 0; k < 3; k++) begin
            drive(0, 8'h00, 0, 0, 1, 8'h00, 0);
            check($sformatf("shrink%0d len", k), 8'(bus.body_length), 8'(2 - k));
            check($sformatf("shrink%0d dead", k), 8'(bus.dragon_dead), 8'(k == 2));
        end
        drive(1, 8'h79, 1, 1, 0, 8'h78, 0);
        check("dead rd_loc", bus.seg_rd_location, 8'h77);
        check("dead len", 8'(bus.body_length), 8'd0);
        drive(0, 8'h00, 0, 0, 1, 8'h78, 0);
        check("dead no shift", bus.seg_rd_location, 8'h77);
        check("dead player_hit", 8'(bus.player_hit), 8'd0);
        check("dead shrink len", 8'(bus.body_length), 8'd0);
        check("dead sticky", 8'(bus.dragon_dead), 8'd1);

        // Grow to the 15-segment limit, saturate, then steer the head onto seg5.
        apply_reset();
        for (int k = 1; k <= 12; k++) drive(1, {4'h7, 4'(7 + k)}, 1, 1, 0, 8'h00, 0);
        check("fill len", 8'(bus.body_length), 8'd15);
        drive(1, 8'h74, 1, 1, 0, 8'h00, 0);
        check("sat len", 8'(bus.body_length), 8'd15);
        drive(0, 8'h00, 0, 0, 1, 8'h00, 0);
        check("sat shrink len", 8'(bus.body_length), 8'd14);
        drive(1, 8'h75, 1, 0, 0, 8'h00, 0);
        check("sat pending cleared", 8'(bus.body_length), 8'd14);
        drive(1, 8'h70, 0, 0, 0, 8'h00, 0);
        check("steer self_hit pre", 8'(bus.self_hit), 8'd0);
        idle(8'h00, 5);
        check("steer self_hit", 8'(bus.self_hit), 8'd1);
        check("steer rd_loc", bus.seg_rd_location, 8'h70);
        check("steer rd_valid", 8'(bus.seg_rd_valid), 8'd1);

        // Asynchronous reset in the middle of a step.
        bus.move_en = 1;
        bus.head_location = 8'h71;
        bus.grow = 1;
        #2 rst = 1'b0;
        #1;
        check("async len", 8'(bus.body_length), 8'd3);
        check("async self_hit", 8'(bus.self_hit), 8'd0);
        check("async rd_loc", bus.seg_rd_location, 8'h00);
        check("async rd_valid", 8'(bus.seg_rd_valid), 8'd0);
        bus.move_en = 0;
        bus.grow = 0;
        @(negedge frame_clk);
        rst = 1'b1;
        idle(8'h00, 0);
        check("post rst rd_loc", bus.seg_rd_location, 8'h76);
        drive(1, 8'h78, 1, 0, 0, 8'h00, 0);
        check("post rst no pending", 8'(bus.body_length), 8'd3);

        for (int run = 0; run < 3; run++) begin
            apply_reset();
            for (int n = 0; n < 300; n++) rand_cycle(run * 1000 + n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
